// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared states, PS/2 command/response bytes and frame bit positions
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_SEND_RST,
    ST_WAIT_TX,
    ST_ACK1,
    ST_BAT,
    ST_ID,
    ST_SEND_EN,
    ST_ACK2,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_FAIL
  } state_t;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  localparam int FRM_START  = 10;
  localparam int FRM_D0     = 9;
  localparam int FRM_PARITY = 1;
  localparam int FRM_STOP   = 0;

endpackage

// File: rtl/ps2_frame_check.sv
// rtl/ps2_frame_check.sv - extracts the data byte from a raw PS/2 frame and flags framing/parity validity
module ps2_frame_check
  import ps2_pkg::*;
(
  input  logic [10:0] rx_frame,
  output logic [7:0]  data,
  output logic        good
);

  always_comb begin
    data = '0;
    for (int i = 0; i < 8; i++) begin
      data[i] = rx_frame[FRM_D0 - i];
    end
    // odd parity: data bits plus parity bit must contain an odd number of ones
    good = !rx_frame[FRM_START] && rx_frame[FRM_STOP] && ((^data) ^ rx_frame[FRM_PARITY]);
  end

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// rtl/ps2_mouse_ctrl.sv - brings a PS/2 mouse into stream mode and decodes 3-byte movement packets
module ps2_mouse_ctrl
  import ps2_pkg::*;
#(
  parameter int INIT_TIMEOUT = 50_000_000,
  parameter int BYTE_TIMEOUT = 50_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic        qzt_clk,
  input  logic        reset,
  input  logic [10:0] rx_frame,
  input  logic        rx_done,
  input  logic        rx_err,
  output logic        rx_enable,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [2:0]  pkt_buttons,
  output logic [8:0]  pkt_dx,
  output logic [8:0]  pkt_dy,
  output logic [1:0]  pkt_ovf,
  output logic        pkt_valid,
  output logic        ready,
  output logic        fail
);

  state_t      state_q, state_d;
  logic        en_phase_q, en_phase_d;
  logic        seen_busy_q, seen_busy_d;
  logic [7:0]  retry_q, retry_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [2:0]  pkt_buttons_q, pkt_buttons_d;
  logic [8:0]  pkt_dx_q, pkt_dx_d, pkt_dy_q, pkt_dy_d;
  logic [1:0]  pkt_ovf_q, pkt_ovf_d;
  logic        pkt_valid_q, pkt_valid_d;

  logic [7:0]  rx_data;
  logic        rx_good;
  logic [7:0]  retry_inc;
  logic        init_to, byte_to;
  logic        tx_start_c, rx_en_c, ready_c, fail_c;
  logic [7:0]  tx_byte_c, exp_rsp;
  state_t      next_ok;

  ps2_frame_check u_frame_check (
    .rx_frame (rx_frame),
    .data     (rx_data),
    .good     (rx_good)
  );

  assign retry_inc = retry_q + 8'd1;
  assign init_to   = (cnt_q >= 32'(INIT_TIMEOUT));
  assign byte_to   = (cnt_q >= 32'(BYTE_TIMEOUT));

  always_comb begin
    state_d       = state_q;
    en_phase_d    = en_phase_q;
    seen_busy_d   = seen_busy_q;
    retry_d       = retry_q;
    b0_d          = b0_q;
    b1_d          = b1_q;
    tx_byte_d     = tx_byte_q;
    pkt_buttons_d = pkt_buttons_q;
    pkt_dx_d      = pkt_dx_q;
    pkt_dy_d      = pkt_dy_q;
    pkt_ovf_d     = pkt_ovf_q;
    pkt_valid_d   = 1'b0;
    tx_start_c    = 1'b0;
    tx_byte_c     = tx_byte_q;
    rx_en_c       = 1'b0;
    ready_c       = 1'b0;
    fail_c        = 1'b0;
    exp_rsp       = RSP_ACK;
    next_ok       = ST_BAT;

    case (state_q)
      ST_SEND_RST, ST_SEND_EN: begin
        tx_byte_c = (state_q == ST_SEND_RST) ? CMD_RESET : CMD_ENABLE;
        if (!tx_busy) begin
          tx_start_c  = 1'b1;
          tx_byte_d   = tx_byte_c;
          en_phase_d  = (state_q == ST_SEND_EN);
          seen_busy_d = 1'b0;
          state_d     = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (tx_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          state_d = en_phase_q ? ST_ACK2 : ST_ACK1;
        end
      end
      ST_ACK1, ST_BAT, ST_ID, ST_ACK2: begin
        rx_en_c = 1'b1;
        ready_c = (state_q == ST_ACK2);
        case (state_q)
          ST_BAT:  begin exp_rsp = RSP_BAT; next_ok = ST_ID;      end
          ST_ID:   begin exp_rsp = RSP_ID;  next_ok = ST_SEND_EN; end
          ST_ACK2: begin exp_rsp = RSP_ACK; next_ok = ST_B0;      end
          default: begin exp_rsp = RSP_ACK; next_ok = ST_BAT;     end
        endcase
        // rx_err beats rx_done; rx_done beats a timeout on the same cycle
        if (rx_err || (rx_done && !(rx_good && rx_data == exp_rsp)) || (!rx_done && init_to)) begin
          retry_d = retry_inc;
          state_d = (retry_inc >= 8'(MAX_RETRY)) ? ST_FAIL : ST_SEND_RST;
        end else if (rx_done) begin
          state_d = next_ok;
        end
      end
      ST_B0: begin
        rx_en_c = 1'b1;
        ready_c = 1'b1;
        if (rx_done && !rx_err && rx_good && rx_data[3]) begin
          b0_d    = rx_data;
          state_d = ST_B1;
        end
      end
      ST_B1, ST_B2: begin
        rx_en_c = 1'b1;
        ready_c = 1'b1;
        if (rx_err || (rx_done && !rx_good) || (!rx_done && byte_to)) begin
          state_d = ST_B0;
        end else if (rx_done && state_q == ST_B1) begin
          b1_d    = rx_data;
          state_d = ST_B2;
        end else if (rx_done) begin
          pkt_buttons_d = b0_q[2:0];
          pkt_dx_d      = {b0_q[4], b1_q};
          pkt_dy_d      = {b0_q[5], rx_data};
          pkt_ovf_d     = {b0_q[7], b0_q[6]};
          pkt_valid_d   = 1'b1;
          state_d       = ST_B0;
        end
      end
      ST_FAIL: begin
        fail_c = 1'b1;
      end
      default: begin
        state_d = ST_SEND_RST;
      end
    endcase

    if (rx_done || state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state_q       <= ST_SEND_RST;
      en_phase_q    <= 1'b0;
      seen_busy_q   <= 1'b0;
      retry_q       <= '0;
      cnt_q         <= '0;
      b0_q          <= '0;
      b1_q          <= '0;
      tx_byte_q     <= '0;
      pkt_buttons_q <= '0;
      pkt_dx_q      <= '0;
      pkt_dy_q      <= '0;
      pkt_ovf_q     <= '0;
      pkt_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_phase_q    <= en_phase_d;
      seen_busy_q   <= seen_busy_d;
      retry_q       <= retry_d;
      cnt_q         <= cnt_d;
      b0_q          <= b0_d;
      b1_q          <= b1_d;
      tx_byte_q     <= tx_byte_d;
      pkt_buttons_q <= pkt_buttons_d;
      pkt_dx_q      <= pkt_dx_d;
      pkt_dy_q      <= pkt_dy_d;
      pkt_ovf_q     <= pkt_ovf_d;
      pkt_valid_q   <= pkt_valid_d;
    end
  end

  // state-decoded outputs are held low while reset is asserted
  assign tx_start    = tx_start_c & ~reset;
  assign tx_byte     = reset ? 8'h00 : tx_byte_c;
  assign rx_enable   = rx_en_c & ~reset;
  assign ready       = ready_c & ~reset;
  assign fail        = fail_c & ~reset;
  assign pkt_buttons = pkt_buttons_q;
  assign pkt_dx      = pkt_dx_q;
  assign pkt_dy      = pkt_dy_q;
  assign pkt_ovf     = pkt_ovf_q;
  assign pkt_valid   = pkt_valid_q;

endmodule
